demux1to3_reg: RTL

- Destination-side counterpart of the 32-bit source-select bus mux: takes one word off the shared datapath bus and steers it into one of three registered destination slots.
- Each slot holds one word until its consumer takes it.
- Sits between the bus and downstream consumers (register loads, MDR/ALU operand latches).
- Valid/ready handshake on the bus side and on each output side.

---
 rtl/demux1to3_reg_pkg.sv | 22 ++
 rtl/demux1to3_reg_slot.sv | 60 ++++++
 rtl/demux1to3_reg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/demux1to3_reg_pkg.sv
// demux1to3_reg_pkg
//   Shared constants and the destination enum for the 1-to-3 registered
//   bus demux (demux1to3_reg) and its slot sub-module (demux_slot).
//   Optional per-slot accept counters are enabled by DEMUX1TO3_COUNT_EN.
package demux1to3_reg_pkg;

    localparam int DATA_W = 32;   // bus word width
    localparam int SEL_W  = 3;    // destination select width
    localparam int CNT_W  = 16;   // per-slot accept counter width

    // Destination codes on sig. NUM_DEST is the first illegal code and
    // doubles as the slot count.
    typedef enum logic [SEL_W-1:0] {
        DEST_0   = 3'd0,
        DEST_1   = 3'd1,
        DEST_2   = 3'd2,
        NUM_DEST = 3'd3
    } dest_e;

    localparam int N_DEST = int'(NUM_DEST);

endpackage

// File: rtl/demux1to3_reg_slot.sv
// demux_slot
//   One registered destination slot: a WIDTH-bit data register plus a valid
//   bit forming an EMPTY/FULL two-state machine (state == valid_o).
//   Ports:
//     clk, clr     rising-edge clock, synchronous active-low reset
//     load_i       top has accepted a bus word for this slot this cycle
//     data_i       bus word to capture on load
//     ready_i      consumer takes the held word this cycle
//     data_o       held word (keeps its last value after drain)
//     valid_o      slot holds an unconsumed word
//     can_load_o   slot can take a new word this cycle (empty or draining)
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             can_load_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A drain in the same cycle frees the register, so a full slot can be
    // refilled back-to-back without a bubble.
    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            // load_i is only raised while can_load_o is true, so a load
            // always wins over a simultaneous drain.
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            // Data is intentionally left in place; consumers qualify it
            // with valid_o.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux1to3_reg.sv
// demux1to3_reg
//   Takes one word off the shared datapath bus and steers it into one of
//   three registered destination slots selected by sig. Valid/ready on the
//   bus side and on each slot output. One cycle bus-to-slot latency, no
//   combinational bus-to-out path.
//   Ports:
//     clk, clr                 rising-edge clock, synchronous active-low reset
//     bus_in, sig, in_valid    bus word, destination select, bus valid
//     in_ready                 combinational: word accepted this cycle
//     out0..out2               registered slot data
//     out0..2_valid/_ready     per-slot handshake
//     sel_err                  sticky: a word with illegal sig was accepted
//     cnt0..cnt2               per-slot accept counters (only when
//                              DEMUX1TO3_COUNT_EN is defined)
module demux1to3_reg
    import demux1to3_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEL_W = demux1to3_reg_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [SEL_W-1:0] sig,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    output logic             sel_err
`ifdef DEMUX1TO3_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
`endif
);

    logic [N_DEST-1:0]            slot_load;
    logic [N_DEST-1:0]            slot_ready;
    logic [N_DEST-1:0]            slot_valid;
    logic [N_DEST-1:0]            slot_can_load;
    logic [N_DEST-1:0][WIDTH-1:0] slot_data;

    logic sel_legal;
    logic accept;
    logic sel_err_q, sel_err_d;

    assign slot_ready = {out2_ready, out1_ready, out0_ready};

    // Illegal selects are always accepted (and dropped) so a bad code can
    // never wedge the bus.
    always_comb begin
        sel_legal = (sig < SEL_W'(N_DEST));
        in_ready  = 1'b1;
        for (int n = 0; n < N_DEST; n++) begin
            if (sig == SEL_W'(n)) in_ready = slot_can_load[n];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        slot_load = '0;
        for (int n = 0; n < N_DEST; n++) begin
            slot_load[n] = accept && (sig == SEL_W'(n));
        end
    end

    for (genvar g = 0; g < N_DEST; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk        (clk),
            .clr        (clr),
            .load_i     (slot_load[g]),
            .data_i     (bus_in),
            .ready_i    (slot_ready[g]),
            .data_o     (slot_data[g]),
            .valid_o    (slot_valid[g]),
            .can_load_o (slot_can_load[g])
        );
    end

    assign out0       = slot_data[DEST_0];
    assign out1       = slot_data[DEST_1];
    assign out2       = slot_data[DEST_2];
    assign out0_valid = slot_valid[DEST_0];
    assign out1_valid = slot_valid[DEST_1];
    assign out2_valid = slot_valid[DEST_2];

    // Sticky until reset.
    assign sel_err_d = sel_err_q || (accept && !sel_legal);

    always_ff @(posedge clk) begin
        if (!clr) sel_err_q <= 1'b0;
        else      sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

`ifdef DEMUX1TO3_COUNT_EN
    logic [N_DEST-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counts follow slot loads, so illegal-select accepts are excluded.
    // Wraps naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        for (int n = 0; n < N_DEST; n++) begin
            cnt_d[n] = cnt_q[n] + CNT_W'(slot_load[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt0 = cnt_q[DEST_0];
    assign cnt1 = cnt_q[DEST_1];
    assign cnt2 = cnt_q[DEST_2];
`endif

endmodule
